// File: rtl/dm_bridge.sv
// Data-memory responder for the CPU DM port: word RAM with byte-lane merge
// plus a memory-mapped countdown timer that raises a registered interrupt.
module dm_bridge #(
  parameter int          RAM_WORDS  = 3072,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DMAdr,
  input  logic        DMcurWE,
  input  logic [3:0]  DMByteEN,
  input  logic [31:0] DMDataW,
  input  logic [31:0] DMcurPC,
  output logic [31:0] DMDataR,
  output logic        IRQ
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [29:0] CTRL_WA   = TIMER_BASE[31:2];
  localparam logic [29:0] PRESET_WA = CTRL_WA + 30'd1;
  localparam logic [29:0] COUNT_WA  = CTRL_WA + 30'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  logic [31:0]      mem [RAM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic             ram_hit, ctrl_hit, preset_hit, count_hit;
  logic             ram_wr, ctrl_wr, preset_wr, full_wr;
  logic [31:0]      ram_merged;

  state_t      state, state_nxt;
  logic        ctrl_en, ctrl_im, irq_flag;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset, count;
  logic        load_cnt, dec_cnt, zero_cnt, set_irq, clr_en;

  // Address decode; byte offset bits only matter for the RAM bound check.
  assign ram_idx    = DMAdr[IDX_W+1:2];
  assign ram_hit    = DMAdr < RAM_BYTES;
  assign ctrl_hit   = DMAdr[31:2] == CTRL_WA;
  assign preset_hit = DMAdr[31:2] == PRESET_WA;
  assign count_hit  = DMAdr[31:2] == COUNT_WA;

  assign full_wr   = DMcurWE && (DMByteEN == 4'hF);
  assign ram_wr    = DMcurWE && ram_hit;
  assign ctrl_wr   = full_wr && ctrl_hit;
  assign preset_wr = full_wr && preset_hit;

  always_comb begin
    ram_merged = mem[ram_idx];
    for (int i = 0; i < 4; i++)
      if (DMByteEN[i]) ram_merged[8*i +: 8] = DMDataW[8*i +: 8];
  end

  // NOTE: reset must clear every word, so this array cannot map to a block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) mem[i] <= '0;
    end else if (ram_wr) begin
      mem[ram_idx] <= ram_merged;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!reset && ram_wr)
      $write("@%h: *%h <= %h\n", DMcurPC, {DMAdr[31:2], 2'b00}, ram_merged);
`endif

  always_comb begin
    DMDataR = '0;
    if (ram_hit)         DMDataR = mem[ram_idx];
    else if (ctrl_hit)   DMDataR = {28'b0, ctrl_im, ctrl_mode, ctrl_en};
    else if (preset_hit) DMDataR = preset;
    else if (count_hit)  DMDataR = count;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_CNT;
      S_CNT: begin
        if (!ctrl_en)           state_nxt = S_IDLE;
        else if (count <= 32'd1) state_nxt = S_INT;
      end
      S_INT:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    zero_cnt = 1'b0;
    set_irq  = 1'b0;
    clr_en   = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LOAD: load_cnt = 1'b1;
      S_CNT: begin
        dec_cnt  = ctrl_en && (count > 32'd1);
        zero_cnt = ctrl_en && (count <= 32'd1);
      end
      S_INT: begin
        set_irq = 1'b1;
        clr_en  = (ctrl_mode != 2'b01);
      end
    endcase
  end

  // NOTE: the last non-blocking assignment wins, so CPU CTRL writes are placed
  // after the FSM updates to take priority over them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      IRQ <= ctrl_im & irq_flag;
      if (load_cnt)      count <= preset;
      else if (dec_cnt)  count <= count - 32'd1;
      else if (zero_cnt) count <= '0;
      if (set_irq) irq_flag <= 1'b1;
      if (clr_en)  ctrl_en  <= 1'b0;
      if (ctrl_wr) begin
        ctrl_en   <= DMDataW[0];
        ctrl_mode <= DMDataW[2:1];
        ctrl_im   <= DMDataW[3];
        irq_flag  <= 1'b0;
      end
      if (preset_wr) preset <= DMDataW;
    end
  end

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: RAM lane merge, decode bounds, timer
// one-shot and auto-reload sequences, interrupt and mid-count reset.
module tb_dm_bridge;

  localparam logic [31:0] T_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] T_PRESET = 32'h0000_7F04;
  localparam logic [31:0] T_COUNT  = 32'h0000_7F08;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DMAdr;
  logic        DMcurWE;
  logic [3:0]  DMByteEN;
  logic [31:0] DMDataW;
  logic [31:0] DMcurPC;
  logic [31:0] DMDataR;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  dm_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .DMAdr    (DMAdr),
    .DMcurWE  (DMcurWE),
    .DMByteEN (DMByteEN),
    .DMDataW  (DMDataW),
    .DMcurPC  (DMcurPC),
    .DMDataR  (DMDataR),
    .IRQ      (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push the expectation as the address is driven, pop it once the read settles.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    DMAdr = a;
    exp_q.push_back(exp);
    #1;
    check(tag, DMDataR, exp_q.pop_front());
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    exp_q.push_back({31'b0, exp});
    #1;
    check(tag, {31'b0, IRQ}, exp_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic [31:0] pc);
    DMAdr    = a;
    DMDataW  = d;
    DMByteEN = be;
    DMcurPC  = pc;
    DMcurWE  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    DMcurWE  = 1'b0;
    DMByteEN = 4'h0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat [5];
    pat[0] = 32'd2; pat[1] = 32'd1; pat[2] = 32'd0; pat[3] = 32'd0; pat[4] = 32'd0;

    reset = 1'b1; DMAdr = '0; DMcurWE = 1'b0; DMByteEN = '0; DMDataW = '0; DMcurPC = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    rd(32'h0000_0000, 32'h0, "reset_ram0");
    rd(32'h0000_2FFC, 32'h0, "reset_ram_last");
    rd(T_COUNT,       32'h0, "reset_count");
    chk_irq(1'b0, "reset_irq");

    // Byte-lane merge and decode bounds
    wr(32'h100, 32'h1122_3344, 4'hF, 32'h0000_3000);
    wr(32'h100, 32'hAABB_CCDD, 4'h6, 32'h0000_3004);
    rd(32'h100, 32'h11BB_CC44, "lane_merge");
    rd(32'h102, 32'h11BB_CC44, "low_bits_ignored");
    wr(32'h100, 32'hFFFF_FFFF, 4'h0, 32'h0000_3008);
    rd(32'h100, 32'h11BB_CC44, "be_zero_no_write");
    wr(32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'h0000_300C);
    rd(32'h2FFC, 32'hCAFE_F00D, "last_word");
    wr(32'h3000, 32'hFFFF_FFFF, 4'hF, 32'h0000_3010);
    rd(32'h3000, 32'h0, "out_of_range");
    rd(32'h2FFC, 32'hCAFE_F00D, "last_word_kept");
    wr(T_COUNT, 32'hFFFF_FFFF, 4'hF, 32'h0000_3014);
    rd(T_COUNT, 32'h0, "count_read_only");
    rd(32'h7F0C, 32'h0, "unmapped");
    wr(T_PRESET, 32'd7, 4'h3, 32'h0000_3018);
    rd(T_PRESET, 32'h0, "preset_partial_ignored");

    // One-shot countdown with interrupt
    wr(T_PRESET, 32'd5, 4'hF, 32'h0000_3020);
    rd(T_PRESET, 32'd5, "preset_set");
    wr(T_CTRL, 32'h9, 4'hF, 32'h0000_3024);
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      rd(T_COUNT, 32'(5 - k), $sformatf("oneshot_count%0d", k));
      tick();
    end
    rd(T_CTRL, 32'h8, "oneshot_enable_cleared");
    tick();
    chk_irq(1'b1, "irq_raised");
    tick(); tick();
    chk_irq(1'b1, "irq_held");
    rd(T_COUNT, 32'h0, "oneshot_count_hold");
    wr(T_CTRL, 32'h0, 4'hF, 32'h0000_3028);
    tick();
    chk_irq(1'b0, "irq_cleared");

    // Auto-reload with an ignored partial CTRL write mid-run
    wr(T_PRESET, 32'd2, 4'hF, 32'h0000_3030);
    wr(T_CTRL, 32'hB, 4'hF, 32'h0000_3034);
    tick(); tick();
    for (int k = 0; k < 15; k++) begin
      rd(T_COUNT, pat[k % 5], $sformatf("reload_count%0d", k));
      if (k == 7) begin
        DMAdr = T_CTRL; DMDataW = 32'h0; DMByteEN = 4'h3; DMcurWE = 1'b1;
      end
      tick();
      DMcurWE = 1'b0; DMByteEN = 4'h0;
    end
    chk_irq(1'b1, "reload_irq_held");
    rd(T_CTRL, 32'hB, "ctrl_partial_ignored");

    // Reset while counting at COUNT=3
    wr(T_CTRL, 32'h0, 4'hF, 32'h0000_3040);
    repeat (6) tick();
    chk_irq(1'b0, "irq_off_after_stop");
    wr(T_PRESET, 32'd4, 4'hF, 32'h0000_3044);
    wr(T_CTRL, 32'h1, 4'hF, 32'h0000_3048);
    tick(); tick(); tick();
    rd(T_COUNT, 32'd3, "count_before_reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(T_COUNT,  32'h0, "reset_mid_count");
    rd(T_CTRL,   32'h0, "reset_mid_ctrl");
    rd(T_PRESET, 32'h0, "reset_mid_preset");
    chk_irq(1'b0, "reset_mid_irq");
    rd(32'h100,  32'h0, "reset_mid_ram");
    rd(32'h2FFC, 32'h0, "reset_mid_ram_last");
    tick(); tick();
    rd(T_COUNT, 32'h0, "idle_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
